freq_div_prog: RTL
==================

FREQ_DIV_PROG -- requirements
Module: freq_div_prog

Interface
REQ-001 Parameter N_CH, default 3: number of independent divided-clock channels, range 1..8.
REQ-002 Parameter CNT_W, default 16: divisor and counter width in bits.
REQ-003 Parameter DEF_DIV, default {16'd100,16'd10,16'd2}: packed N_CH*CNT_W reset divisors, with channel k at bits [k*CNT_W +: CNT_W].
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port CLK_in, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-006 Port RST, input, 1 bit: synchronous, active-high reset.
REQ-007 Port EN, input, N_CH bits: per-channel count enable.
REQ-008 Port DIV_wr, input, 1 bit: single-cycle divisor write strobe.
REQ-009 Port DIV_ch, input, 3 bits: target channel index for the write.
REQ-010 Port DIV_val, input, CNT_W bits: new divisor D.
REQ-011 Port DIV_ack, output, 1 bit: one-cycle pulse when a write is accepted.
REQ-012 Port DIV_err, output, 1 bit: one-cycle pulse when a write is rejected.
REQ-013 Port DIV_pend, output, N_CH bits: per-channel flag, set while an accepted divisor is waiting to be applied.
REQ-014 Port CLK_out, output, N_CH bits: registered divided clocks.
REQ-015 Port TICK, output, N_CH bits: one-cycle pulse in the cycle a CLK_out bit rises.

Function
REQ-016 Each channel SHALL hold: active divisor D, pending divisor P, counter cnt (CNT_W bits), CLK_out bit. Define H = ceil(D/2), computed as (D+1)>>1.
REQ-017 When EN[k]=1, on each cycle, channel k SHALL apply the first matching rule below:
- cnt==D-1: cnt<=0; CLK_out<=1; TICK<=1; if DIV_pend[k], D<=P and DIV_pend[k]<=0.
- cnt==H-1: cnt<=cnt+1; CLK_out<=0; TICK<=0.
- otherwise: cnt<=cnt+1; CLK_out holds; TICK<=0.
REQ-018 The resulting period SHALL be exactly D cycles, with the high phase H cycles and the low phase D-H cycles; D=2 gives a 1-high/1-low toggle.
REQ-019 When EN[k]=0, cnt, CLK_out and D of channel k SHALL hold, and TICK[k] SHALL be 0; counting resumes from the held state.
REQ-020 A write SHALL be accepted when DIV_wr=1, DIV_ch<N_CH and DIV_val>=2. On acceptance: P[DIV_ch]<=DIV_val, DIV_pend[DIV_ch]<=1, and DIV_ack=1 in the next cycle.
REQ-021 A write with DIV_ch>=N_CH or DIV_val<2 SHALL be rejected: no state change, and DIV_err=1 in the next cycle.
REQ-022 A second accepted write before the pending value is applied SHALL overwrite P (last write wins); DIV_pend stays 1.
REQ-023 If a write is accepted in the same cycle as the channel's wrap (cnt==D-1), the wrap SHALL use the previous P, or keep D if nothing was pending; the new value SHALL become pending afterwards.
REQ-024 Divisor changes SHALL take effect only at a wrap, so CLK_out never produces a runt pulse.
REQ-025 Channels SHALL be fully independent; a write to one channel SHALL NOT disturb the others.

Reset
REQ-026 While RST=1 at a clock edge, the following SHALL hold:
- cnt=0, CLK_out=0, TICK=0, DIV_ack=0, DIV_err=0, DIV_pend=0;
- D[k]=P[k]=DEF_DIV[k];
- RST has priority over EN and DIV_wr.
REQ-027 Reset mid-period SHALL abandon the period and any pending divisor; the first CLK_out rise after release occurs D cycles after the first enabled cycle.

Verification
REQ-028 Default parameters, EN=3'b111, RST released -> CLK_out[0] period 2 cycles, CLK_out[1] period 10 (5 high/5 low), CLK_out[2] period 100 (50/50); first rises at cycles 2, 10 and 100.
REQ-029 Write ch1 D=7 mid-period -> DIV_ack pulse and DIV_pend[1]=1; current 10-cycle period completes intact; then 7-cycle periods with 4 high/3 low; DIV_pend[1] clears at the wrap.
REQ-030 Write DIV_val=1, then DIV_ch=5 -> two DIV_err pulses; no DIV_pend change; periods unchanged.
REQ-031 EN[2]=0 for 13 cycles mid-high-phase -> CLK_out[2] and cnt frozen, TICK[2]=0; afterwards the period is 113 cycles for that instance only.
REQ-032 Two writes to ch0 (D=4, then D=6) before wrap -> D=6 applied; write coincident with wrap -> applied at the following wrap.
REQ-033 RST asserted for 1 cycle with D[1]=7 pending -> all outputs 0 and D[1]=10, followed by the REQ-028 timing.

Source files
------------

// File: rtl/freq_div_prog_if.sv
// Divisor-programming bus for freq_div_prog: write request, accept/reject
// pulses and per-channel pending flags.
interface freq_div_prog_if #(
    parameter int unsigned N_CH  = 3,
    parameter int unsigned CNT_W = 16
);
    logic             DIV_wr;
    logic [2:0]       DIV_ch;
    logic [CNT_W-1:0] DIV_val;
    logic             DIV_ack;
    logic             DIV_err;
    logic [N_CH-1:0]  DIV_pend;

    modport master (
        output DIV_wr, DIV_ch, DIV_val,
        input  DIV_ack, DIV_err, DIV_pend
    );

    modport slave (
        input  DIV_wr, DIV_ch, DIV_val,
        output DIV_ack, DIV_err, DIV_pend
    );
endinterface

// File: rtl/freq_div_prog.sv
// Multi-channel programmable clock divider. Each channel produces a registered
// divided clock whose divisor can be reprogrammed glitch-free at period wraps.
module freq_div_prog #(
    parameter int unsigned            N_CH    = 3,
    parameter int unsigned            CNT_W   = 16,
    parameter logic [N_CH*CNT_W-1:0]  DEF_DIV = {16'd100, 16'd10, 16'd2}
) (
    input  logic             CLK_in,
    input  logic             RST,
    input  logic [N_CH-1:0]  EN,
    freq_div_prog_if.slave   div,
    output logic [N_CH-1:0]  CLK_out,
    output logic [N_CH-1:0]  TICK
);

    logic [CNT_W-1:0] d_q   [N_CH];
    logic [CNT_W-1:0] p_q   [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [N_CH-1:0]  pend_q;
    logic             ack_q;
    logic             err_q;
    logic             wr_ok_c;

    // High-phase length ceil(D/2); widened so D near full scale cannot overflow.
    function automatic logic [CNT_W-1:0] half_of(input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, d} + (CNT_W+1)'(1);
        return CNT_W'(s >> 1);
    endfunction

    assign wr_ok_c = div.DIV_wr && (32'(div.DIV_ch) < N_CH) &&
                     (div.DIV_val >= CNT_W'(2));

    assign div.DIV_ack  = ack_q;
    assign div.DIV_err  = err_q;
    assign div.DIV_pend = pend_q;

    always_ff @(posedge CLK_in) begin
        if (RST) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                cnt_q[k] <= '0;
                d_q[k]   <= DEF_DIV[k*CNT_W +: CNT_W];
                p_q[k]   <= DEF_DIV[k*CNT_W +: CNT_W];
            end
            CLK_out <= '0;
            TICK    <= '0;
            pend_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= wr_ok_c;
            err_q <= div.DIV_wr && !wr_ok_c;
            for (int unsigned k = 0; k < N_CH; k++) begin
                TICK[k] <= 1'b0;
                if (EN[k]) begin
                    if (cnt_q[k] == d_q[k] - CNT_W'(1)) begin
                        cnt_q[k]   <= '0;
                        CLK_out[k] <= 1'b1;
                        TICK[k]    <= 1'b1;
                        if (pend_q[k]) begin
                            d_q[k]    <= p_q[k];
                            pend_q[k] <= 1'b0;
                        end
                    end else begin
                        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                        if (cnt_q[k] == half_of(d_q[k]) - CNT_W'(1))
                            CLK_out[k] <= 1'b0;
                    end
                end
                // Placed after the wrap so a same-cycle write stays pending for the next wrap.
                if (wr_ok_c && (div.DIV_ch == 3'(k))) begin
                    p_q[k]    <= div.DIV_val;
                    pend_q[k] <= 1'b1;
                end
            end
        end
    end

endmodule
